hdb3_encode: RTL and testbench
==============================

Name: hdb3_encode

Overview:
- HDB3 line encoder. Takes the NRZ bit stream and drives the dual unipolar rails BP/BN that the decode_top receive chain consumes.
- Sits directly upstream of the decoder, in the same clock domain.
- Symbols advance one per `data_valid` strobe, so the bit period is set by the strobe rate.
- Implements zero-run detection, B/V substitution with retroactive B insertion, and alternating-polarity mapping.

Parameters:
- CNT_W, 16, width of optional violation counter.
- INIT_POL, 0, polarity of the "last pulse" after reset (0 = last pulse negative, so the first pulse goes on BP).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high (1 = reset) despite the suffix; sampled on clk only.
- data_in  input  1  NRZ data bit, sampled when data_valid=1.
- data_valid  input  1  one-cycle strobe per bit period; the pipeline advances only on strobes.
- BP  output  1  positive-rail pulse for the current symbol.
- BN  output  1  negative-rail pulse for the current symbol.
- out_valid  output  1  one-cycle pulse, one clk after each strobe, once the pipeline has filled.
- v_count  output  CNT_W  number of V symbols emitted (optional feature; constant 0 when absent).

Behaviour:
- Reset (rst_n=1 at a clk edge) applies to all state:
  - BP=0, BN=0, out_valid=0, v_count=0.
  - Pipeline cleared to ZERO symbols, fill counter=0.
  - Zero-run counter=0, parity=0 (even), polarity=INIT_POL.
  - Reset mid-stream discards all pending symbols; no partial output.
- Symbol codes (2 bits): ZERO, ONE, B, V.
- Input stage, on each strobe:
  - data_in=1: write ONE into stage0, zrun←0, parity toggles.
  - data_in=0 and zrun<3: write ZERO, zrun+1.
  - data_in=0 and zrun=3 (4th consecutive zero): write V into stage0 and zrun←0.
    - If parity is even, the symbol shifting into stage3 in this same cycle (the first zero of the run) is rewritten as B.
    - Parity←0 after every V, whether or not B was inserted.
- Pipeline:
  - 4-deep shift register, stage0 (newest) to stage3 (oldest), shifts only on strobes.
  - Fill counter saturates at 4.
- Output stage:
  - On each strobe the symbol leaving stage3 is mapped and registered into BP/BN.
  - ONE or B: polarity toggles; new polarity 1 → BP=1, 0 → BN=1.
  - V: polarity unchanged; pulse on the rail of the last pulse.
  - ZERO: BP=BN=0.
  - BP and BN are never both 1.
  - Outputs hold between strobes.
- Latency and out_valid:
  - A bit accepted on strobe n appears on BP/BN in the cycle after strobe n+4.
  - out_valid=1 in that cycle only when the fill counter was already 4 at the strobe; the first four strobes after reset give BP=BN=0 and out_valid=0.
- data_valid gaps of any length: no state change, outputs hold.
- Back-to-back strobes on every clk are supported.
- Runs longer than 4 zeros: substitution repeats every 4 zeros. Parity after a V is even, so the next all-zero run always becomes B00V.

Optional Feature:
- Macro: HDB3_VCNT_EN.
- Defined:
  - v_count increments by 1 in the cycle a V symbol is registered onto BP/BN.
  - Saturates at all-ones.
  - Cleared by reset.
- Undefined: no counter logic; v_count tied to 0.
- Encoding behaviour is identical either way.

Test Plan:
- Reset, then strobe 1,1,1,1 followed by four more 1s → from the 5th strobe onward, out_valid pulses and the rails alternate BP,BN,BP,BN.
- Reset, then 0,0,0,0 plus 4 filler 1s → B00V on BP,–,–,BP (B and V both positive); then the fillers on BN,BP,BN,BP.
- Reset, then 1,0,0,0,0 plus 4 filler 1s → BP, 0, 0, 0, then V on BP (odd parity, no B), then fillers BN,BP,BN,BP.
- Reset, then 1,1,0,0,0,0,0,0,0,0 plus 4 filler 1s:
  - First run → BP,BN,B on BP,0,0,V on BP.
  - Second run (parity reset) → B on BN,0,0,V on BN.
  - With HDB3_VCNT_EN, v_count=2.
- Random gaps of 0–5 cycles between strobes on a mixed pattern → the BP/BN sequence is identical to the gap-free run; outputs hold during gaps; BP&BN never both 1.
- Assert rst_n for 1 cycle while a 0,0,0 run is mid-pipeline → all outputs 0 next cycle. A following 0,0,0,0 encodes as B00V starting on BP (state fully restarted, no leftover B/V).

Source files
------------

// File: rtl/hdb3_encode.sv
// HDB3 line encoder: NRZ bits in, dual unipolar rails BP/BN out, four-symbol look-ahead pipeline.
// Optional V-symbol counter on v_count is enabled by defining HDB3_VCNT_EN.
module hdb3_encode #(
    parameter int   CNT_W    = 16,
    parameter logic INIT_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_valid,
    output logic             BP,
    output logic             BN,
    output logic             out_valid,
    output logic [CNT_W-1:0] v_count
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_B    = 2'd2,
        SYM_V    = 2'd3
    } sym_t;

    sym_t       sym_p0, sym_p1, sym_p2, sym_p3;
    logic [1:0] zrun;
    logic       parity;
    logic       pol;
    logic [2:0] fill;

    sym_t       in_sym;
    logic [1:0] zrun_nxt;
    logic       parity_nxt;
    logic       b_ins;
    logic [2:0] map_res;

    // Returns {new_polarity, bp, bn} for the symbol leaving the pipeline.
    function automatic logic [2:0] map_sym(input sym_t s, input logic last_pol);
        logic np;
        logic bp;
        logic bn;
        np = last_pol;
        bp = 1'b0;
        bn = 1'b0;
        case (s)
            SYM_ONE, SYM_B: begin
                np = ~last_pol;
                bp = np;
                bn = ~np;
            end
            SYM_V: begin
                bp = last_pol;
                bn = ~last_pol;
            end
            default: begin
                bp = 1'b0;
                bn = 1'b0;
            end
        endcase
        return {np, bp, bn};
    endfunction

    always_comb begin
        in_sym     = SYM_ZERO;
        zrun_nxt   = zrun;
        parity_nxt = parity;
        b_ins      = 1'b0;
        if (data_in) begin
            in_sym     = SYM_ONE;
            zrun_nxt   = 2'd0;
            parity_nxt = ~parity;
        end else if (zrun == 2'd3) begin
            // Fourth zero: V here, and B replaces the run's first zero (now in stage2) on even parity.
            in_sym     = SYM_V;
            zrun_nxt   = 2'd0;
            parity_nxt = 1'b0;
            b_ins      = ~parity;
        end else begin
            zrun_nxt   = zrun + 2'd1;
        end
    end

    assign map_res = map_sym(sym_p3, pol);

    // Stage p0..p3: symbol pipeline; output register follows p3.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sym_p0    <= SYM_ZERO;
            sym_p1    <= SYM_ZERO;
            sym_p2    <= SYM_ZERO;
            sym_p3    <= SYM_ZERO;
            zrun      <= 2'd0;
            parity    <= 1'b0;
            pol       <= INIT_POL;
            fill      <= 3'd0;
            BP        <= 1'b0;
            BN        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (data_valid) begin
                sym_p0    <= in_sym;
                sym_p1    <= sym_p0;
                sym_p2    <= sym_p1;
                sym_p3    <= b_ins ? SYM_B : sym_p2;
                zrun      <= zrun_nxt;
                parity    <= parity_nxt;
                pol       <= map_res[2];
                BP        <= map_res[1];
                BN        <= map_res[0];
                out_valid <= (fill == 3'd4);
                if (fill != 3'd4) begin
                    fill <= fill + 3'd1;
                end
            end
        end
    end

`ifdef HDB3_VCNT_EN
    logic [CNT_W-1:0] vcnt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            vcnt_q <= '0;
        end else if (data_valid && (sym_p3 == SYM_V) && (vcnt_q != {CNT_W{1'b1}})) begin
            vcnt_q <= vcnt_q + CNT_W'(1);
        end
    end

    assign v_count = vcnt_q;
`else
    assign v_count = '0;
`endif

endmodule

// File: tb/tb_hdb3_encode.sv
// Self-checking bench for hdb3_encode: directed patterns, reset cases, and random streams
// checked against a sequence-level HDB3 reference model.
module tb_hdb3_encode;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             data_in = 1'b0;
    logic             data_valid = 1'b0;
    logic             BP;
    logic             BN;
    logic             out_valid;
    logic [CNT_W-1:0] v_count;

    int errors = 0;
    int checks = 0;

    bit rand_bits[$];
    bit gf_bp[$];
    bit gf_bn[$];
    bit exp_bp[$];
    bit exp_bn[$];
    bit exp_ov[$];
    int exp_vc[$];

    always #5 clk = ~clk;

    hdb3_encode #(.CNT_W(CNT_W), .INIT_POL(1'b0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .BP(BP),
        .BN(BN),
        .out_valid(out_valid),
        .v_count(v_count)
    );

    function automatic int vexp(input int n);
`ifdef HDB3_VCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Whole-stream HDB3: build the symbol list with retroactive B, then map polarities.
    // Symbols: 0 zero, 1 one, 2 B, 3 V. Output for strobe k is symbol k-4.
    function automatic void build_model(input bit bits[$]);
        int sym[$];
        int ones = 0;
        int zeros = 0;
        int last = -1;
        int vc = 0;
        exp_bp.delete(); exp_bn.delete(); exp_ov.delete(); exp_vc.delete();
        foreach (bits[i]) begin
            if (bits[i]) begin
                sym.push_back(1); ones++; zeros = 0;
            end else begin
                zeros++;
                if (zeros == 4) begin
                    if (ones % 2 == 0) sym[sym.size()-3] = 2;
                    sym.push_back(3); ones = 0; zeros = 0;
                end else begin
                    sym.push_back(0);
                end
            end
        end
        for (int k = 0; k < bits.size(); k++) begin
            int pulse = 0;
            if (k >= 4) begin
                case (sym[k-4])
                    1, 2: begin last = -last; pulse = last; end
                    3: begin pulse = last; vc++; end
                    default: pulse = 0;
                endcase
            end
            exp_bp.push_back(pulse > 0);
            exp_bn.push_back(pulse < 0);
            exp_ov.push_back(k >= 4);
            exp_vc.push_back(vexp(vc));
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        data_valid = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic strobe(input bit d);
        @(negedge clk);
        data_in = d;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({BP, BN, out_valid} !== 3'b000 || v_count !== '0) begin
            errors++;
            $display("FAIL reset_state: BP=%b BN=%b ov=%b vc=%0d, required all 0", BP, BN, out_valid, v_count);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({BP, BN, out_valid} !== 3'b000 || v_count !== '0) begin
            errors++;
            $display("FAIL reset_idle: BP=%b BN=%b ov=%b vc=%0d, required all 0", BP, BN, out_valid, v_count);
        end
    endtask

    task automatic test_patterns();
        string pat[4];
        string rails[4];
        int    nv[4];
        pat[0] = "11111111";           rails[0] = "+-+-";           nv[0] = 0;
        pat[1] = "000011111111";       rails[1] = "+00+-+-+";       nv[1] = 1;
        pat[2] = "1000011111111";      rails[2] = "+000+-+-+";      nv[2] = 1;
        pat[3] = "110000000011111111"; rails[3] = "+-+00+-00-+-+-"; nv[3] = 2;
        for (int c = 0; c < 4; c++) begin
            do_reset();
            for (int k = 0; k < pat[c].len(); k++) begin
                bit eb;
                bit en;
                bit eo;
                strobe(pat[c][k] == "1");
                eb = 1'b0; en = 1'b0; eo = 1'b0;
                if (k >= 4) begin
                    eb = (rails[c][k-4] == "+");
                    en = (rails[c][k-4] == "-");
                    eo = 1'b1;
                end
                checks++;
                if (BP !== eb || BN !== en || out_valid !== eo) begin
                    errors++;
                    $display("FAIL pattern%0d strobe%0d: BP=%b BN=%b ov=%b, required BP=%b BN=%b ov=%b",
                             c, k + 1, BP, BN, out_valid, eb, en, eo);
                end
            end
            checks++;
            if (v_count !== CNT_W'(vexp(nv[c]))) begin
                errors++;
                $display("FAIL pattern%0d v_count: got %0d, required %0d", c, v_count, vexp(nv[c]));
            end
        end
    endtask

    task automatic test_mid_reset();
        string pre;
        string post;
        string rails;
        pre = "11000";
        post = "000011111111";
        rails = "+00+-+-+";
        do_reset();
        for (int k = 0; k < pre.len(); k++) strobe(pre[k] == "1");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({BP, BN, out_valid} !== 3'b000 || v_count !== '0) begin
            errors++;
            $display("FAIL mid_reset_clear: BP=%b BN=%b ov=%b vc=%0d, required all 0", BP, BN, out_valid, v_count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < post.len(); k++) begin
            bit eb;
            bit en;
            strobe(post[k] == "1");
            eb = (k >= 4) && (rails[k-4] == "+");
            en = (k >= 4) && (rails[k-4] == "-");
            checks++;
            if (BP !== eb || BN !== en || out_valid !== (k >= 4)) begin
                errors++;
                $display("FAIL mid_reset_restart strobe%0d: BP=%b BN=%b ov=%b, required BP=%b BN=%b ov=%b",
                         k + 1, BP, BN, out_valid, eb, en, (k >= 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        rand_bits.delete();
        gf_bp.delete();
        gf_bn.delete();
        for (int i = 0; i < 80; i++) rand_bits.push_back($urandom_range(0, 2) == 0);
        build_model(rand_bits);
        do_reset();
        foreach (rand_bits[k]) begin
            strobe(rand_bits[k]);
            gf_bp.push_back(BP);
            gf_bn.push_back(BN);
            checks++;
            if (BP !== exp_bp[k] || BN !== exp_bn[k] || out_valid !== exp_ov[k] ||
                v_count !== CNT_W'(exp_vc[k]) || (BP && BN)) begin
                errors++;
                $display("FAIL b2b strobe%0d: BP=%b BN=%b ov=%b vc=%0d, required BP=%b BN=%b ov=%b vc=%0d",
                         k + 1, BP, BN, out_valid, v_count, exp_bp[k], exp_bn[k], exp_ov[k], exp_vc[k]);
            end
        end
    endtask

    task automatic test_random_gaps();
        bit pb;
        bit pn;
        build_model(rand_bits);
        do_reset();
        pb = 1'b0;
        pn = 1'b0;
        foreach (rand_bits[k]) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                checks++;
                if (BP !== pb || BN !== pn || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold before strobe%0d: BP=%b BN=%b ov=%b, required BP=%b BN=%b ov=0",
                             k + 1, BP, BN, out_valid, pb, pn);
                end
            end
            strobe(rand_bits[k]);
            checks++;
            if (BP !== exp_bp[k] || BN !== exp_bn[k] || out_valid !== exp_ov[k] ||
                BP !== gf_bp[k] || BN !== gf_bn[k] || (BP && BN)) begin
                errors++;
                $display("FAIL gaps strobe%0d: BP=%b BN=%b ov=%b, required BP=%b BN=%b ov=%b (gap-free BP=%b BN=%b)",
                         k + 1, BP, BN, out_valid, exp_bp[k], exp_bn[k], exp_ov[k], gf_bp[k], gf_bn[k]);
            end
            pb = BP;
            pn = BN;
        end
        checks++;
        if (v_count !== CNT_W'(exp_vc[rand_bits.size()-1])) begin
            errors++;
            $display("FAIL gaps v_count: got %0d, required %0d", v_count, exp_vc[rand_bits.size()-1]);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_mid_reset();
        test_back_to_back();
        test_random_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
